// File: rtl/product_accumulator.sv
// Sums 8-bit multiplier products into an ACC_W-bit accumulator and reads it out byte-serially, LSB first.
// Optional build macro: PACC_SAT_EN (clamp the accumulator on overflow instead of wrapping).
module product_accumulator #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [7:0]       prod_in,
    input  logic             prod_valid,
    input  logic             clear,
    input  logic             rd_start,
    output logic             busy,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int unsigned NBYTES = ACC_W / 8;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t                  state;
    logic [ACC_W-1:0]        acc;
    logic [NBYTES-1:0][7:0]  snap;
    logic [IDX_W-1:0]        rd_idx;
    logic                    byte_valid_q;
    logic [ACC_W:0]          sum_c;

    // One extra bit on the sum exposes the carry used for overflow detection.
    assign sum_c = {1'b0, acc} + (ACC_W + 1)'(prod_in);

    // Accumulator, product count and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (ena) begin
            if (clear) begin
                acc      <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else if (prod_valid) begin
                count <= (count == CNT_MAX) ? count : count + CNT_W'(1);
                if (sum_c[ACC_W]) begin
                    overflow <= 1'b1;
`ifdef PACC_SAT_EN
                    acc <= '1;
`else
                    acc <= sum_c[ACC_W-1:0];
`endif
                end else begin
                    acc <= sum_c[ACC_W-1:0];
                end
            end
        end
    end

    // Readout FSM: snapshot on request, then one byte per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            snap         <= '0;
            rd_idx       <= '0;
            byte_out     <= '0;
            byte_valid_q <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    byte_valid_q <= 1'b0;
                    if (rd_start) begin
                        snap   <= acc;
                        rd_idx <= '0;
                        state  <= READ;
                    end
                end
                READ: begin
                    byte_out     <= snap[rd_idx];
                    byte_valid_q <= 1'b1;
                    if (rd_idx == LAST_IDX) begin
                        rd_idx <= '0;
                        state  <= IDLE;
                    end else begin
                        rd_idx <= rd_idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A frozen pipeline must not present a held byte as new data.
    assign byte_valid = byte_valid_q & ena;
    assign busy       = (state == READ);

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator (ACC_W=16, CNT_W=4); expectations follow PACC_SAT_EN when defined.
module tb_product_accumulator;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] prod_in;
    logic       prod_valid;
    logic       clear;
    logic       rd_start;
    logic       busy;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [3:0] count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    product_accumulator #(.ACC_W(16), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .clear      (clear),
        .rd_start   (rd_start),
        .busy       (busy),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .count      (count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        pv;
        logic        clr;
        logic [7:0]  prod;
        logic [3:0]  exp_cnt;
        logic        exp_ovf;
        logic        do_rd;
        logic [15:0] exp_acc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_n(input logic [7:0] p, input int n);
        prod_valid = 1'b1;
        prod_in    = p;
        repeat (n) step();
        prod_valid = 1'b0;
        prod_in    = 8'h00;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Full readout of a 16-bit accumulator with latency and busy checks.
    task automatic rd_check(input string name, input logic [15:0] exp);
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        check({name, " busy0"}, 32'(busy), 32'd1);
        check({name, " bv0"}, 32'(byte_valid), 32'd0);
        step();
        check({name, " bv1"}, 32'(byte_valid), 32'd1);
        check({name, " lo"}, 32'(byte_out), 32'(exp[7:0]));
        check({name, " busy1"}, 32'(busy), 32'd1);
        step();
        check({name, " bv2"}, 32'(byte_valid), 32'd1);
        check({name, " hi"}, 32'(byte_out), 32'(exp[15:8]));
        check({name, " busy2"}, 32'(busy), 32'd0);
        step();
        check({name, " bv3"}, 32'(byte_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] exp_ovf_acc;
        logic [15:0] exp_ovf_acc2;
`ifdef PACC_SAT_EN
        exp_ovf_acc  = 16'hFFFF;
        exp_ovf_acc2 = 16'hFFFF;
`else
        exp_ovf_acc  = 16'h00A4;
        exp_ovf_acc2 = 16'h00B4;
`endif
        vecs[0] = '{pv: 1'b0, clr: 1'b1, prod: 8'h00, exp_cnt: 4'd0, exp_ovf: 1'b0, do_rd: 1'b0, exp_acc: 16'h0000};
        vecs[1] = '{pv: 1'b1, clr: 1'b0, prod: 8'hE1, exp_cnt: 4'd1, exp_ovf: 1'b0, do_rd: 1'b0, exp_acc: 16'h0000};
        vecs[2] = '{pv: 1'b1, clr: 1'b0, prod: 8'hE1, exp_cnt: 4'd2, exp_ovf: 1'b0, do_rd: 1'b0, exp_acc: 16'h0000};
        vecs[3] = '{pv: 1'b1, clr: 1'b0, prod: 8'h06, exp_cnt: 4'd3, exp_ovf: 1'b0, do_rd: 1'b1, exp_acc: 16'h01C8};
        vecs[4] = '{pv: 1'b0, clr: 1'b1, prod: 8'h00, exp_cnt: 4'd0, exp_ovf: 1'b0, do_rd: 1'b0, exp_acc: 16'h0000};
        vecs[5] = '{pv: 1'b1, clr: 1'b0, prod: 8'h50, exp_cnt: 4'd1, exp_ovf: 1'b0, do_rd: 1'b1, exp_acc: 16'h0050};
        vecs[6] = '{pv: 1'b1, clr: 1'b1, prod: 8'h09, exp_cnt: 4'd0, exp_ovf: 1'b0, do_rd: 1'b1, exp_acc: 16'h0000};
        vecs[7] = '{pv: 1'b1, clr: 1'b0, prod: 8'h00, exp_cnt: 4'd1, exp_ovf: 1'b0, do_rd: 1'b1, exp_acc: 16'h0000};

        rst_n = 1'b0; ena = 1'b1; prod_in = 8'h00; prod_valid = 1'b0; clear = 1'b0; rd_start = 1'b0;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst bv", 32'(byte_valid), 32'd0);
        check("rst byte", 32'(byte_out), 32'd0);
        check("rst count", 32'(count), 32'd0);
        check("rst ovf", 32'(overflow), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Table-driven accumulate / clear sequence.
        for (int i = 0; i < 8; i++) begin
            prod_valid = vecs[i].pv;
            clear      = vecs[i].clr;
            prod_in    = vecs[i].prod;
            step();
            prod_valid = 1'b0;
            clear      = 1'b0;
            prod_in    = 8'h00;
            check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            if (vecs[i].do_rd)
                rd_check($sformatf("vec%0d rd", i), vecs[i].exp_acc);
        end

        // Overflow: 292 x 0xE1 = 65700.
        do_clear();
        add_n(8'hE1, 292);
        check("ovf count", 32'(count), 32'd15);
        check("ovf flag", 32'(overflow), 32'd1);
        rd_check("ovf rd", exp_ovf_acc);
        add_n(8'h10, 1);
        check("ovf sticky", 32'(overflow), 32'd1);
        check("ovf count sat", 32'(count), 32'd15);
        rd_check("ovf rd2", exp_ovf_acc2);

        // Snapshot isolation: accumulate during READ, ignored second rd_start.
        do_clear();
        add_n(8'hFF, 18);
        add_n(8'h46, 1);
        rd_start = 1'b1;
        step();
        prod_valid = 1'b1;
        prod_in    = 8'h10;
        step();
        rd_start   = 1'b0;
        prod_valid = 1'b0;
        prod_in    = 8'h00;
        check("snap lo", 32'(byte_out), 32'h34);
        check("snap bv1", 32'(byte_valid), 32'd1);
        step();
        check("snap hi", 32'(byte_out), 32'h12);
        check("snap busy end", 32'(busy), 32'd0);
        step();
        check("snap no requeue busy", 32'(busy), 32'd0);
        check("snap no requeue bv", 32'(byte_valid), 32'd0);
        rd_check("post snap", 16'h1244);
        check("post snap ovf", 32'(overflow), 32'd0);

        // ena gap between readout bytes.
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        check("gap lo", 32'(byte_out), 32'h44);
        ena        = 1'b0;
        prod_valid = 1'b1;
        prod_in    = 8'hFF;
        #1;
        check("gap bv forced", 32'(byte_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("gap%0d bv", i), 32'(byte_valid), 32'd0);
            check($sformatf("gap%0d busy", i), 32'(busy), 32'd1);
        end
        ena        = 1'b1;
        prod_valid = 1'b0;
        prod_in    = 8'h00;
        step();
        check("gap hi", 32'(byte_out), 32'h12);
        check("gap hi bv", 32'(byte_valid), 32'd1);
        step();
        check("gap end bv", 32'(byte_valid), 32'd0);
        rd_check("gap acc", 16'h1244);

        // Asynchronous reset during the first readout byte.
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        check("arst pre bv", 32'(byte_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst bv", 32'(byte_valid), 32'd0);
        check("arst busy", 32'(busy), 32'd0);
        check("arst byte", 32'(byte_out), 32'd0);
        check("arst count", 32'(count), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("arst idle", 32'(busy), 32'd0);
        rd_check("arst acc", 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
